// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans a square frame buffer and drives a VGA stream.
// The image is centred in the visible area; everything outside the image
// window is black. The display only switches between blank and image at
// frame boundaries, so a frame is never torn.
module vga_frame_reader #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 16,
  parameter int PIX_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int IMG_X0  = 192,
  parameter int IMG_Y0  = 112
) (
  input  logic               CLK,
  input  logic               NRST,
  input  logic               FRAME_READY,
  output logic [A_WIDTH-1:0] RD_ADDR,
  input  logic [D_WIDTH-1:0] RD_DATA,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic               VGA_EN,
  output logic [D_WIDTH-1:0] VGA_DATA,
  output logic               FRAME_START
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HALF  = A_WIDTH / 2;
  localparam int IMG   = 1 << HALF;
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] X0 = 10'(IMG_X0);
  localparam logic [9:0] X1 = 10'(IMG_X0 + IMG);
  localparam logic [9:0] Y0 = 10'(IMG_Y0);
  localparam logic [9:0] Y1 = 10'(IMG_Y0 + IMG);
  localparam logic [HALF-1:0] X0_LO = HALF'(IMG_X0);
  localparam logic [HALF-1:0] Y0_LO = HALF'(IMG_Y0);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         h_q, h_d, v_q, v_d;
  logic               frame_start_q;

  logic               de_p1_q, hs_p1_q, vs_p1_q, en_p1_q;
  logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic               hs_p2_q, vs_p2_q, de_p2_q, en_p2_q;
  logic [D_WIDTH-1:0] data_p2_q;

  logic               tick, boundary, show;
  logic               de_d, hs_d, vs_d, win_d;
  logic [HALF-1:0]    rx, ry;

  assign tick     = (div_q == DIV_LAST);
  assign boundary = (h_q == 10'd0) && (v_q == 10'd0);
  assign show     = (state_q == SHOW);

  assign de_d  = (h_q < H_VIS_C) && (v_q < V_VIS_C);
  assign hs_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign win_d = (h_q >= X0) && (h_q < X1) && (v_q >= Y0) && (v_q < Y1);

  // Offsets into the image; only meaningful while inside the window.
  assign rx = h_q[HALF-1:0] - X0_LO;
  assign ry = v_q[HALF-1:0] - Y0_LO;

  // Next-state of the pixel divider and the h/v scan counters.
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    h_d       = h_q;
    v_d       = v_q;
    rd_addr_d = rd_addr_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    if (win_d && show) rd_addr_d = A_WIDTH'({ry, rx});
  end

  // Stage 0: pixel divider and scan position.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Blank/show state, switched only at a frame boundary, plus the frame-start pulse.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q       <= BLANK;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (tick && boundary) begin
        case (state_q)
          BLANK:   if (FRAME_READY) state_q <= SHOW;
          SHOW:    if (!FRAME_READY) state_q <= BLANK;
          default: state_q <= BLANK;
        endcase
        frame_start_q <= FRAME_READY;
      end
    end
  end

  // Stage 1: timing flags and buffer read address.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      de_p1_q   <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      en_p1_q   <= 1'b0;
      rd_addr_q <= '0;
    end else if (tick) begin
      de_p1_q   <= de_d;
      hs_p1_q   <= hs_d;
      vs_p1_q   <= vs_d;
      en_p1_q   <= de_d && win_d && show;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Stage 2: aligned outputs; buffer data has settled since the address changed.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      hs_p2_q   <= 1'b1;
      vs_p2_q   <= 1'b1;
      de_p2_q   <= 1'b0;
      en_p2_q   <= 1'b0;
      data_p2_q <= '0;
    end else if (tick) begin
      hs_p2_q   <= hs_p1_q;
      vs_p2_q   <= vs_p1_q;
      de_p2_q   <= de_p1_q;
      en_p2_q   <= en_p1_q;
      data_p2_q <= en_p1_q ? RD_DATA : '0;
    end
  end

  assign RD_ADDR     = rd_addr_q;
  assign VGA_HS      = hs_p2_q;
  assign VGA_VS      = vs_p2_q;
  assign VGA_DE      = de_p2_q;
  assign VGA_EN      = en_p2_q;
  assign VGA_DATA    = data_p2_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a scaled-down raster:
// 54 x 37 total (40 x 30 visible), 16 x 16 image at (12,7), PIX_DIV = 2.
// Pixel n = v*54 + h of a frame starting at cycle base B is on the outputs
// after posedge B + 2n + 4; its read address is on RD_ADDR after B + 2n + 2.
module tb_vga_frame_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fr;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       hs, vs, de, en, fs;
  logic [7:0] vdata;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int fs_cnt = 0, en_cnt = 0, nz_cnt = 0, de_cnt = 0, hs_low = 0, vs_low = 0;
  int first_en = -1;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .D_WIDTH(8), .A_WIDTH(8), .PIX_DIV(2),
    .H_VIS(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_X0(12), .IMG_Y0(7)
  ) dut (
    .CLK(clk), .NRST(rst_n), .FRAME_READY(fr),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de), .VGA_EN(en),
    .VGA_DATA(vdata), .FRAME_START(fs)
  );

  // Synchronous buffer model: data = address ^ 0x5A, one CLK latency.
  always @(posedge clk) rd_data <= rd_addr ^ 8'h5A;

  // Per-CLK activity counters sampled away from the active edge.
  always @(negedge clk) begin
    if (fs) fs_cnt++;
    if (en) en_cnt++;
    if (en && first_en < 0) first_en = cyc;
    if (vdata != 8'h00) nz_cnt++;
    if (de) de_cnt++;
    if (!hs) hs_low++;
    if (!vs) vs_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    fr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_de", 32'(de), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_data", 32'(vdata), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_fs", 32'(fs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Frame 0, FRAME_READY low: raster timing only.
    adv_to(3);    chk("de_pre", 32'(de), 0);
    adv_to(4);    chk("de_px0", 32'(de), 1);
    adv_to(82);   chk("de_px39", 32'(de), 1);
    adv_to(84);   chk("de_px40", 32'(de), 0);
    adv_to(91);   chk("hs_before", 32'(hs), 1);
    adv_to(92);   chk("hs_fall", 32'(hs), 0);
    adv_to(103);  chk("hs_last", 32'(hs), 0);
    adv_to(104);  chk("hs_rise", 32'(hs), 1);
    adv_to(784);
    chk("f0_win_en", 32'(en), 0);
    chk("f0_win_data", 32'(vdata), 0);
    chk("f0_win_addr", 32'(rd_addr), 0);
    adv_to(2160);
    fr = 1'b1;
    adv_to(2296);
    chk("f0_late_en", 32'(en), 0);
    chk("f0_late_data", 32'(vdata), 0);
    chk("f0_late_addr", 32'(rd_addr), 0);
    adv_to(3458); chk("vs_l31", 32'(vs), 1);
    adv_to(3460); chk("vs_l32", 32'(vs), 0);
    adv_to(3674); chk("vs_l33", 32'(vs), 0);
    adv_to(3676); chk("vs_l34", 32'(vs), 1);
    adv_to(3997);
    chk("f0_fs_cnt", 32'(fs_cnt), 0);
    chk("f0_en_cnt", 32'(en_cnt), 0);
    chk("f0_nz_cnt", 32'(nz_cnt), 0);
    chk("f0_de_cnt", 32'(de_cnt), 2400);
    chk("f0_hs_low", 32'(hs_low), 444);
    chk("f0_vs_low", 32'(vs_low), 216);

    // Frame 1 (base 3996): image shown.
    adv_to(3998); chk("fs_pulse", 32'(fs), 1);
    adv_to(3999); chk("fs_end", 32'(fs), 0);
    adv_to(4778);
    chk("addr_12_7", 32'(rd_addr), 32'h00);
    chk("en_11_7", 32'(en), 0);
    chk("data_11_7", 32'(vdata), 0);
    adv_to(4780);
    chk("en_12_7", 32'(en), 1);
    chk("data_12_7", 32'(vdata), 32'h5A);
    adv_to(4812);
    chk("en_28_7", 32'(en), 0);
    chk("data_28_7", 32'(vdata), 0);
    adv_to(4902); chk("addr_20_8", 32'(rd_addr), 32'h18);
    adv_to(4904);
    chk("en_20_8", 32'(en), 1);
    chk("data_20_8", 32'(vdata), 32'h42);
    fr = 1'b0;
    adv_to(6428); chk("addr_27_22", 32'(rd_addr), 32'hFF);
    adv_to(6430);
    chk("en_27_22", 32'(en), 1);
    chk("data_27_22", 32'(vdata), 32'hA5);
    adv_to(7993);
    chk("first_en_cyc", 32'(first_en), 4780);
    chk("f1_en_cnt", 32'(en_cnt), 512);

    // Frame 2 (base 7992): blank again, address holds.
    adv_to(8000); chk("f2_fs_cnt", 32'(fs_cnt), 1);
    adv_to(8774); chk("f2_addr_hold", 32'(rd_addr), 32'hFF);
    adv_to(8776);
    chk("f2_en", 32'(en), 0);
    chk("f2_data", 32'(vdata), 0);

    // Asynchronous reset mid-line while HS is low.
    adv_to(12084);
    chk("pre_rst_hs", 32'(hs), 0);
    chk("pre_rst_addr", 32'(rd_addr), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hs", 32'(hs), 1);
    chk("mid_rst_vs", 32'(vs), 1);
    chk("mid_rst_de", 32'(de), 0);
    chk("mid_rst_en", 32'(en), 0);
    chk("mid_rst_data", 32'(vdata), 0);
    chk("mid_rst_addr", 32'(rd_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    adv_to(91); chk("re_hs_before", 32'(hs), 1);
    adv_to(92); chk("re_hs_fall", 32'(hs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
